button_pulse_gen: RTL and testbench
===================================

BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a level change (10 ms at 12 MHz); legal range 2..2^20-1.
REQ-002 Parameter: REPEAT_DELAY, 6000000, cycles from accepted press to first auto-repeat pulse; legal range 2..2^24-1.
REQ-003 Parameter: REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeat pulses; legal range 2..2^24-1.
REQ-004 Port: CLK  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port: RESET  input  1  reset, synchronous and active-high.
REQ-006 Port: BTN_IN  input  1  raw asynchronous, bouncing push-button, 1 = pressed.
REQ-007 Port: PULSE  output  1  one-cycle strobe per accepted press (plus repeats); drives a toggle/count input directly.
REQ-008 Port: REL_PULSE  output  1  one-cycle strobe per accepted release.
REQ-009 Port: LEVEL  output  1  debounced button level.

Function
REQ-010 BTN_IN SHALL pass through a two-flop synchronizer; only the second flop output (SYNC) feeds logic.
REQ-011 FSM SHALL have states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE: SYNC=1 -> PRESS_WAIT with counter loaded 1; else stay.
REQ-013 PRESS_WAIT: SYNC=0 -> IDLE, counter cleared; SYNC=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-014 PRESSED: SYNC=0 -> RELEASE_WAIT, counter loaded 1; else stay.
REQ-015 RELEASE_WAIT: SYNC=1 -> PRESSED, counter cleared, no pulse; SYNC=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-016 PULSE SHALL be registered, high for exactly the one cycle following the PRESS_WAIT->PRESSED transition.
REQ-017 REL_PULSE SHALL be registered, high for exactly the one cycle following the RELEASE_WAIT->IDLE transition.
REQ-018 LEVEL SHALL be 1 exactly while in PRESSED or RELEASE_WAIT.
REQ-019 Latency: BTN_IN held 1 from sampling edge k -> PULSE high after edge k+DEBOUNCE_CYCLES+2, for one cycle; same latency release -> REL_PULSE.
REQ-020 Any bounce shorter than DEBOUNCE_CYCLES SHALL produce no PULSE, REL_PULSE or LEVEL change.
REQ-021 PULSE and REL_PULSE SHALL never be high in the same cycle.
REQ-022 Counters SHALL saturate-free: width ceil(log2(max param)), never wrap within legal ranges.

Reset
REQ-023 RESET=1 at a rising edge SHALL set FSM=IDLE, all counters=0, synchronizer flops=0, PULSE=0, REL_PULSE=0, LEVEL=0.
REQ-024 RESET SHALL override all inputs, including mid-debounce and mid-repeat.
REQ-025 Button held through reset release SHALL be treated as a new press: PULSE after full REQ-019 latency from first post-reset edge.

Configuration
REQ-026 Macro BUTTON_PULSE_GEN_AUTOREPEAT_EN SHALL compile auto-repeat in or out.
REQ-027 Defined: in PRESSED, repeat counter counts from the PRESSED entry; PULSE fires one cycle at REPEAT_DELAY cycles after the first PULSE, then every REPEAT_PERIOD cycles while PRESSED.
REQ-028 Defined: repeat counter cleared on leaving PRESSED; RELEASE_WAIT->PRESSED bounce-back restarts REPEAT_DELAY timing without a pulse.
REQ-029 Not defined: exactly one PULSE per accepted press; REPEAT_DELAY/REPEAT_PERIOD ignored; no repeat counter logic synthesized.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-030 Clean press: BTN_IN 0->1 sampled at edge 10, held -> PULSE high only after edge 20, LEVEL 1 from edge 20.
REQ-031 Bounce: BTN_IN high 5 cycles, low 3, high 6, then low -> no PULSE, LEVEL stays 0.
REQ-032 Release: held press, BTN_IN 1->0 at edge 50, held -> REL_PULSE high only after edge 60, LEVEL 0 from edge 60.
REQ-033 Reset mid-debounce: RESET at edge 15 of a press starting edge 10, BTN_IN held, RESET low from edge 16 -> no PULSE before edge 26; PULSE after edge 26.
REQ-034 Auto-repeat (macro defined): press held 40 cycles after first PULSE -> PULSEs at first+0, +20, +25, +30, +35, +40; macro undefined -> single PULSE.

Source files
------------

// File: rtl/button_pulse_gen.sv
// button_pulse_gen
// Debounces a raw push-button and turns accepted presses into single-cycle
// strobes. A two-flop synchronizer feeds a four-state debounce FSM; LEVEL,
// PULSE and REL_PULSE are registered one cycle after the FSM settles.
//
// Optional feature: define BUTTON_PULSE_GEN_AUTOREPEAT_EN to add auto-repeat
// (extra PULSE strobes while the button stays pressed). With the macro
// undefined each accepted press yields exactly one PULSE.
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_IN,
  output logic PULSE,
  output logic REL_PULSE,
  output logic LEVEL
);

  // Counter widths cover the full legal parameter range, so no wrap can occur.
  localparam int DB_W  = 20;
  localparam int RPT_W = 24;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_next;

  logic sync_p0;
  logic sync_p1;

  logic pulse_p2;
  logic rel_pulse_p2;
  logic level_p2;

  logic rpt_hit;

  // Reject illegal parameterisations at elaboration time.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_debounce
    $error("button_pulse_gen: DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_DELAY < 2 || REPEAT_DELAY > 16777215) begin : g_bad_delay
    $error("button_pulse_gen: REPEAT_DELAY out of range");
  end
  if (REPEAT_PERIOD < 2 || REPEAT_PERIOD > 16777215) begin : g_bad_period
    $error("button_pulse_gen: REPEAT_PERIOD out of range");
  end

  // True once the debounce counter has seen the last required stable cycle.
  function automatic logic db_done(input logic [DB_W-1:0] cnt);
    return cnt == DB_LAST;
  endfunction

  // Next value of the debounce counter while a level change is pending.
  function automatic logic [DB_W-1:0] db_step(input logic [DB_W-1:0] cnt);
    return cnt + DB_W'(1);
  endfunction

  // Two-flop synchronizer; only sync_p1 is used by the logic below.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= BTN_IN;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce FSM state and counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_next;
      db_cnt <= db_cnt_next;
    end
  end

  // Debounce FSM next-state: a level change is accepted only after
  // DEBOUNCE_CYCLES consecutive samples of the new level.
  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    case (state)
      IDLE: begin
        if (sync_p1) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = DB_W'(1);
        end else begin
          db_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_p1) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else if (db_done(db_cnt)) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_step(db_cnt);
        end
      end
      PRESSED: begin
        if (!sync_p1) begin
          state_next  = RELEASE_WAIT;
          db_cnt_next = DB_W'(1);
        end else begin
          db_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed returns silently: LEVEL never dropped.
        if (sync_p1) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
        end else if (db_done(db_cnt)) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_step(db_cnt);
        end
      end
      default: begin
        state_next  = IDLE;
        db_cnt_next = '0;
      end
    endcase
  end

`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] RPT_DELAY_CNT  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_CNT = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;

  // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
  assign rpt_hit = (state == PRESSED) &&
                   (rpt_cnt == (rpt_first ? RPT_DELAY_CNT : RPT_PERIOD_CNT));

  // Repeat timer: runs only while PRESSED, restarts on every PRESSED entry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state != PRESSED) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_hit) begin
      rpt_cnt   <= RPT_W'(1);
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt + RPT_W'(1);
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  // Output registers. level_p2 holds last cycle's debounced level, so a
  // PRESSED state with level_p2 low marks the first cycle after acceptance,
  // and IDLE with level_p2 high marks the first cycle after release.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pulse_p2     <= 1'b0;
      rel_pulse_p2 <= 1'b0;
      level_p2     <= 1'b0;
    end else begin
      level_p2     <= (state == PRESSED) || (state == RELEASE_WAIT);
      pulse_p2     <= ((state == PRESSED) && !level_p2) || rpt_hit;
      rel_pulse_p2 <= (state == IDLE) && level_p2;
    end
  end

  assign PULSE     = pulse_p2;
  assign REL_PULSE = rel_pulse_p2;
  assign LEVEL     = level_p2;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Testbench for button_pulse_gen (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20,
// REPEAT_PERIOD=5). Honours BUTTON_PULSE_GEN_AUTOREPEAT_EN like the design.
module tb_button_pulse_gen;

  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic BTN_IN = 1'b0;
  logic PULSE;
  logic REL_PULSE;
  logic LEVEL;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BTN_IN(BTN_IN),
    .PULSE(PULSE),
    .REL_PULSE(REL_PULSE),
    .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int base = 0;

  // Reference model: accepted level plus length of the current run of
  // samples that disagree with it; level changes after D disagreeing samples.
  logic m_s1 = 1'b0, m_s2 = 1'b0;
  logic m_acc = 1'b0;
  int   m_run = 0;
  logic m_ev_press = 1'b0, m_ev_rel = 1'b0;
  int   m_pstart = -1;
  logic e_pulse = 1'b0, e_rel = 1'b0, e_lvl = 1'b0;

  int pq[$];
  int rq[$];
  int lvl_first = -1;
  int lvl_last = -1;
  int lvl_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic b, input logic r);
    logic s;
    logic in_p, now_p, rep;
    int d;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0;
      m_ev_press = 0; m_ev_rel = 0; m_pstart = -1;
      e_pulse = 0; e_rel = 0; e_lvl = 0;
      return;
    end
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    in_p = m_acc && (m_run == 0);
    rep = 1'b0;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
    if (in_p && m_pstart >= 0) begin
      d = cyc - m_pstart;
      rep = (d >= RD + 1) && (((d - RD - 1) % RP) == 0);
    end
`else
    d = 0;
`endif
    e_pulse = m_ev_press || rep;
    e_rel   = m_ev_rel;
    e_lvl   = m_acc;
    m_ev_press = 0;
    m_ev_rel = 0;
    if (s == m_acc) m_run = 0;
    else begin
      m_run++;
      if (m_run == D) begin
        m_acc = s;
        m_run = 0;
        if (s) m_ev_press = 1; else m_ev_rel = 1;
      end
    end
    now_p = m_acc && (m_run == 0);
    if (now_p && !in_p) m_pstart = cyc;
    else if (!now_p) m_pstart = -1;
  endtask

  task automatic tick(input logic b, input logic r);
    int rel;
    BTN_IN = b;
    RESET = r;
    @(posedge CLK);
    cyc++;
    model_step(b, r);
    #1;
    chk("PULSE", int'(PULSE), int'(e_pulse));
    chk("REL_PULSE", int'(REL_PULSE), int'(e_rel));
    chk("LEVEL", int'(LEVEL), int'(e_lvl));
    rel = cyc - base;
    if (PULSE) pq.push_back(rel);
    if (REL_PULSE) rq.push_back(rel);
    if (LEVEL) begin
      lvl_cnt++;
      if (lvl_first < 0) lvl_first = rel;
      lvl_last = rel;
    end
  endtask

  task automatic start_scn();
    base = cyc;
    pq.delete();
    rq.delete();
    lvl_first = -1;
    lvl_last = -1;
    lvl_cnt = 0;
  endtask

  // Tick until the scenario-relative edge number reaches 'upto'.
  task automatic run(input int upto, input logic b, input logic r);
    while (cyc - base < upto) tick(b, r);
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  initial begin
    int remaining;
    logic lvl;
    int exp_rpt_a, exp_rpt_d;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
    exp_rpt_a = 4;
    exp_rpt_d = 6;
`else
    exp_rpt_a = 1;
    exp_rpt_d = 1;
`endif

    // Reset state
    repeat (3) tick(1'b1, 1'b1);
    chk("rst_pulse", int'(PULSE), 0);
    chk("rst_rel", int'(REL_PULSE), 0);
    chk("rst_level", int'(LEVEL), 0);
    repeat (5) tick(1'b0, 1'b0);

    // Clean press at edge 10, release at edge 50
    start_scn();
    run(9, 1'b0, 1'b0);
    run(49, 1'b1, 1'b0);
    run(75, 1'b0, 1'b0);
    chk("press_first_pulse_edge", first_of(pq), 20);
    chk("press_level_rise_edge", lvl_first, 20);
    chk("press_pulse_count", pq.size(), exp_rpt_a);
    chk("release_rel_count", rq.size(), 1);
    chk("release_rel_edge", first_of(rq), 60);
    chk("release_level_last_high", lvl_last, 59);

    // Bounce: 5 high, 3 low, 6 high, then low
    start_scn();
    run(5, 1'b1, 1'b0);
    run(8, 1'b0, 1'b0);
    run(14, 1'b1, 1'b0);
    run(40, 1'b0, 1'b0);
    chk("bounce_pulse_count", pq.size(), 0);
    chk("bounce_level_cycles", lvl_cnt, 0);
    chk("bounce_rel_count", rq.size(), 0);

    // Reset mid-debounce: press at 10, RESET at 15, button held
    start_scn();
    run(9, 1'b0, 1'b0);
    run(14, 1'b1, 1'b0);
    run(15, 1'b1, 1'b1);
    run(40, 1'b1, 1'b0);
    run(70, 1'b0, 1'b0);
    chk("rstmid_first_pulse_edge", first_of(pq), 26);
    chk("rstmid_pulse_count", pq.size(), 1);
    chk("rstmid_level_rise_edge", lvl_first, 26);

    // Long hold: press at 10 held through edge 60
    start_scn();
    run(9, 1'b0, 1'b0);
    run(60, 1'b1, 1'b0);
    run(90, 1'b0, 1'b0);
    chk("hold_first_pulse_edge", first_of(pq), 20);
    chk("hold_pulse_count", pq.size(), exp_rpt_d);
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
    if (pq.size() >= 3) begin
      chk("hold_second_pulse_edge", pq[1], 40);
      chk("hold_third_pulse_edge", pq[2], 45);
    end else begin
      chk("hold_repeat_present", pq.size(), 3);
    end
`endif

    // Random bouncing, long holds and occasional resets
    start_scn();
    remaining = 0;
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (remaining == 0) begin
        lvl = ~lvl;
        remaining = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                : int'($urandom_range(1, 12));
      end
      remaining--;
      tick(lvl, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    chk("random_saw_pulses", (pq.size() > 0) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
